load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_pkg: access-mode codes, FSM encoding and access legality check
// Rev 1.0
// ------------------------------------------------------------------
package lsu_pkg;

  localparam int c_TIMEOUT_DEFAULT = 16;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsuState_e;

  // Legal mode for the direction, exactly one direction requested, and aligned.
  function automatic logic lsuAccessOk(
    input logic       isLoad,
    input logic       isStore,
    input logic [2:0] funct3,
    input logic [1:0] addrLo
  );
    logic modeOk;
    logic alignOk;
    if (isStore) begin
      modeOk = (funct3 == c_F3_B) || (funct3 == c_F3_H) || (funct3 == c_F3_W);
    end else begin
      modeOk = (funct3 == c_F3_B) || (funct3 == c_F3_H) || (funct3 == c_F3_W) ||
               (funct3 == c_F3_BU) || (funct3 == c_F3_HU);
    end
    case (funct3[1:0])
      2'b01:   alignOk = (addrLo[0] == 1'b0);
      2'b10:   alignOk = (addrLo == 2'b00);
      default: alignOk = 1'b1;
    endcase
    return (isLoad ^ isStore) && modeOk && alignOk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_lane_align: store strobes/lane replication and load extraction
// Rev 1.0
// ------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_storeFunct3,
  input  logic [1:0]  i_storeAddrLo,
  input  logic [31:0] i_storeData,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_laneData,
  input  logic [2:0]  i_loadFunct3,
  input  logic [1:0]  i_loadAddrLo,
  input  logic [31:0] i_busData,
  output logic [31:0] o_loadData
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_strobe   = 4'b1111;
    o_laneData = i_storeData;
    case (i_storeFunct3[1:0])
      2'b00: begin
        o_strobe   = 4'b0001 << i_storeAddrLo;
        o_laneData = {4{i_storeData[7:0]}};
      end
      2'b01: begin
        o_strobe   = 4'b0011 << {i_storeAddrLo[1], 1'b0};
        o_laneData = {2{i_storeData[15:0]}};
      end
      default: begin
        o_strobe   = 4'b1111;
        o_laneData = i_storeData;
      end
    endcase
  end

  // Halfword accesses are aligned, so a byte-granular shift lands either lane at bit 0.
  assign w_shifted = i_busData >> {i_loadAddrLo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_loadData = i_busData;
    case (i_loadFunct3)
      c_F3_B:  o_loadData = {{24{w_byte[7]}}, w_byte};
      c_F3_H:  o_loadData = {{16{w_half[15]}}, w_half};
      c_F3_BU: o_loadData = {24'd0, w_byte};
      c_F3_HU: o_loadData = {16'd0, w_half};
      default: o_loadData = i_busData;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// load_store_unit: MEM-stage bus master with pipeline stall and timeout
// Rev 1.0
// ------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] write_data_m,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        lsu_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  lsuState_e          r_state;
  lsuState_e          w_nextState;
  logic [c_CNT_W-1:0] r_count;
  logic [2:0]         r_funct3;
  logic [1:0]         r_addrLo;

  logic        w_req;
  logic        w_legal;
  logic        w_issue;
  logic        w_err;
  logic        w_ackDone;
  logic        w_timeout;
  logic [3:0]  w_strobe;
  logic [31:0] w_laneData;
  logic [31:0] w_loadData;

  assign w_req   = mem_read_m | mem_write_m;
  assign w_legal = lsuAccessOk(mem_read_m, mem_write_m, funct3_m, addr_m[1:0]);

  lsu_lane_align u_laneAlign (
    .i_storeFunct3 (funct3_m),
    .i_storeAddrLo (addr_m[1:0]),
    .i_storeData   (write_data_m),
    .o_strobe      (w_strobe),
    .o_laneData    (w_laneData),
    .i_loadFunct3  (r_funct3),
    .i_loadAddrLo  (r_addrLo),
    .i_busData     (bus_rdata),
    .o_loadData    (w_loadData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    stall_m     = 1'b0;
    w_issue     = 1'b0;
    w_err       = 1'b0;
    w_ackDone   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_legal) begin
            stall_m     = 1'b1;
            w_issue     = 1'b1;
            w_nextState = ST_BUSY;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall_m = 1'b1;
        if (bus_ack) begin
          w_ackDone   = 1'b1;
          w_nextState = ST_DONE;
        end else if (r_count == c_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = ST_DONE;
        end
      end
      // The stalled instruction is still on the inputs here; let it retire.
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_wstrb   <= 4'd0;
      bus_wdata   <= 32'd0;
      read_data_m <= 32'd0;
      lsu_error   <= 1'b0;
      r_count     <= '0;
      r_funct3    <= 3'd0;
      r_addrLo    <= 2'd0;
    end else begin
      lsu_error <= w_err | w_timeout;
      if (w_issue) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write_m;
        bus_addr  <= {addr_m[31:2], 2'b00};
        bus_wstrb <= mem_write_m ? w_strobe : 4'd0;
        bus_wdata <= w_laneData;
        r_funct3  <= funct3_m;
        r_addrLo  <= addr_m[1:0];
        r_count   <= '0;
      end else if (r_state == ST_BUSY && !w_ackDone && !w_timeout) begin
        r_count <= r_count + 1'b1;
      end
      if (w_ackDone) begin
        bus_req <= 1'b0;
        if (!bus_we) begin
          read_data_m <= w_loadData;
        end
      end
      if (w_timeout || w_err) begin
        bus_req     <= 1'b0;
        read_data_m <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire
